// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter
// Hands each SDRAM slot to exactly one of the downloader, the RAM eraser or
// the Z80 CPU. Downloader writes are edge-detected and queued in a small
// FIFO so that multi-cycle write pulses turn into exactly one SDRAM write.
// All sd_* outputs are registered and change only when a slot starts.

module sdram_req_arbiter #(
    parameter int ADDR_W     = 25,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              sys_clock,
    input  logic              reset_n,
    input  logic              slot,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    input  logic              er_busy,
    input  logic              er_wr,
    input  logic [ADDR_W-1:0] er_addr,
    input  logic [7:0]        er_data,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_dout,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [7:0]        sd_din,
    output logic              sd_we,
    output logic              sd_oe,
    output logic              cpu_wait,
    output logic [1:0]        grant,
    output logic              dl_overflow
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = ADDR_W + 8;

    // Slot owner encoding doubles as the grant output value
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DL   = 2'd1;
    localparam logic [1:0] ST_ER   = 2'd2;
    localparam logic [1:0] ST_CPU  = 2'd3;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     fifo_count;
    logic               dl_wr_q;
    logic [1:0]         state;

    logic               dl_push;
    logic               fifo_empty;
    logic               fifo_full;
    logic               dl_accept;
    logic               dl_pop;
    logic [ENTRY_W-1:0] fifo_head;

    // A write is a rising edge of dl_wr; a full FIFO drops it even if the
    // same cycle pops, so the overflow flag reflects the occupancy the
    // writer actually saw.
    assign dl_push    = dl_wr & ~dl_wr_q;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
    assign dl_accept  = dl_push & ~fifo_full;
    assign dl_pop     = slot & ~fifo_empty;
    assign fifo_head  = fifo_mem[rd_ptr];

    // FIFO storage: payload is sampled in the cycle the edge is detected
    always_ff @(posedge sys_clock) begin
        if (dl_accept) begin
            fifo_mem[wr_ptr] <= {dl_addr, dl_data};
        end
    end

    // Edge register, FIFO pointers/occupancy and the sticky overflow flag
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            dl_wr_q     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            dl_overflow <= 1'b0;
        end else begin
            dl_wr_q <= dl_wr;
            if (dl_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (dl_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({dl_accept, dl_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (dl_push & fifo_full) begin
                dl_overflow <= 1'b1;
            end
        end
    end

    // Slot owner selection and registered SDRAM request, updated only at slot start
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            sd_addr <= '0;
            sd_din  <= '0;
            sd_we   <= 1'b0;
            sd_oe   <= 1'b0;
        end else if (slot) begin
            if (!fifo_empty) begin
                state   <= ST_DL;
                sd_addr <= fifo_head[ENTRY_W-1:8];
                sd_din  <= fifo_head[7:0];
                sd_we   <= 1'b1;
                sd_oe   <= 1'b0;
            end else if (er_busy & er_wr) begin
                state   <= ST_ER;
                sd_addr <= er_addr;
                sd_din  <= er_data;
                sd_we   <= 1'b1;
                sd_oe   <= 1'b0;
            end else if (dl_active | er_busy) begin
                state   <= ST_IDLE;
                sd_we   <= 1'b0;
                sd_oe   <= 1'b0;
            end else if (cpu_rd | cpu_wr) begin
                state   <= ST_CPU;
                sd_addr <= {{(ADDR_W-16){1'b0}}, cpu_addr};
                sd_din  <= cpu_dout;
                sd_we   <= cpu_wr;
                sd_oe   <= cpu_rd & ~cpu_wr;
            end else begin
                state   <= ST_IDLE;
                sd_we   <= 1'b0;
                sd_oe   <= 1'b0;
            end
        end
    end

    assign grant = state;

    // The CPU is stalled whenever it wants memory but does not own the slot,
    // and unconditionally while downloads/erases run or reset is held.
    assign cpu_wait = ~reset_n | dl_active | er_busy
                    | ((cpu_rd | cpu_wr) & (state != ST_CPU));

endmodule
